// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory stream loader.
// The all-zero word ends a program, the same rule the CPU uses.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_ERROR   = 3'd4
    } state_e;

    localparam logic [31:0] TERMINATOR_WORD = 32'h0;
    localparam int          BYTES_PER_WORD  = 4;
    localparam int          BYTE_IDX_W      = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_stream_loader_if.sv
// Byte stream in and instruction-memory write port out, bundled together.
// The master view belongs to the loader and the slave view to the environment.
interface imem_stream_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_stream_loader_byte_word_packer.sv
// Assembles little-endian bytes into 32-bit words. word_valid is a
// combinational pulse in the cycle the last byte of a word is accepted.
module byte_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_fire,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word_data
);
    localparam int LOW_W = 8 * (BYTES_PER_WORD - 1);

    logic [BYTE_IDX_W-1:0] idx_q, idx_d;
    logic [LOW_W-1:0]      low_q, low_d;

    // Earlier bytes shift down so byte 0 ends up in the least significant lane.
    always_comb begin
        idx_d      = idx_q;
        low_d      = low_q;
        word_valid = 1'b0;
        word_data  = {byte_data, low_q};
        if (clear) begin
            idx_d = '0;
            low_d = '0;
        end else if (byte_fire) begin
            low_d = {byte_data, low_q[LOW_W-1:8]};
            if (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1)) begin
                idx_d      = '0;
                word_valid = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q <= '0;
            low_q <= '0;
        end else begin
            idx_q <= idx_d;
            low_q <= low_d;
        end
    end

endmodule

// File: rtl/imem_stream_loader.sv
// Boot loader: packs a byte stream into instruction memory while holding the
// CPU in reset, then releases it RELEASE_DELAY cycles after the terminator.
module imem_stream_loader
    import imem_loader_pkg::*;
#(
    parameter int IMEM_DEPTH    = 256,
    parameter int ADDR_W        = 8,
    parameter int RELEASE_DELAY = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    imem_stream_loader_if.master bus,
    output logic                 cpu_reset,
    output logic                 load_done,
    output logic                 load_error,
    output logic [ADDR_W:0]      word_count
);
    localparam int                CNT_W     = $clog2(RELEASE_DELAY + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              in_ready_q, in_ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              load_done_q, load_done_d;
    logic              load_error_q, load_error_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic [CNT_W-1:0]  rel_cnt_q, rel_cnt_d;

    logic              byte_fire;
    logic              word_valid;
    logic [31:0]       word_data;

    assign byte_fire = bus.in_valid && in_ready_q;

    byte_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (start),
        .byte_fire  (byte_fire),
        .byte_data  (bus.in_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = 1'b0;
        imem_addr_d  = imem_addr_q;
        wdata_d      = wdata_q;
        cpu_reset_d  = cpu_reset_q;
        load_done_d  = load_done_q;
        load_error_d = load_error_q;
        word_count_d = word_count_q;
        rel_cnt_d    = rel_cnt_q;
        if (start) begin
            state_d      = ST_LOAD;
            addr_d       = '0;
            imem_addr_d  = '0;
            word_count_d = '0;
            cpu_reset_d  = 1'b1;
            load_done_d  = 1'b0;
            load_error_d = 1'b0;
            rel_cnt_d    = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (word_valid) begin
                        we_d         = 1'b1;
                        imem_addr_d  = addr_q;
                        wdata_d      = word_data;
                        word_count_d = word_count_q + 1'b1;
                        // A terminator in the last slot is still a clean end.
                        if (word_data == TERMINATOR_WORD) begin
                            state_d   = ST_RELEASE;
                            rel_cnt_d = CNT_W'(RELEASE_DELAY);
                        end else if (addr_q == LAST_ADDR) begin
                            state_d      = ST_ERROR;
                            load_error_d = 1'b1;
                        end else begin
                            addr_d = addr_q + 1'b1;
                        end
                    end
                end
                ST_RELEASE: begin
                    // Outputs are registered, so the count-of-one cycle
                    // decides the edge on which the CPU leaves reset.
                    if (rel_cnt_q == CNT_W'(1)) begin
                        state_d     = ST_RUN;
                        cpu_reset_d = 1'b0;
                        load_done_d = 1'b1;
                    end else begin
                        rel_cnt_d = rel_cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
        in_ready_d = (state_d == ST_LOAD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            in_ready_q   <= 1'b0;
            we_q         <= 1'b0;
            imem_addr_q  <= '0;
            wdata_q      <= '0;
            cpu_reset_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            word_count_q <= '0;
            rel_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            in_ready_q   <= in_ready_d;
            we_q         <= we_d;
            imem_addr_q  <= imem_addr_d;
            wdata_q      <= wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
            word_count_q <= word_count_d;
            rel_cnt_q    <= rel_cnt_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_reset      = cpu_reset_q;
    assign load_done      = load_done_q;
    assign load_error     = load_error_q;
    assign word_count     = word_count_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed bench for imem_stream_loader: a 256-word instance for loads,
// restarts and resets, plus a 4-word instance for overflow.
`timescale 1ns/1ps
module tb_imem_stream_loader;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic start4 = 1'b0;
    always #5 clk = ~clk;

    imem_stream_loader_if #(.ADDR_W(8)) s ();
    imem_stream_loader_if #(.ADDR_W(2)) s4 ();

    logic       cpu_reset, load_done, load_error;
    logic [8:0] word_count;
    logic       cpu_reset4, load_done4, load_error4;
    logic [2:0] word_count4;

    imem_stream_loader #(.IMEM_DEPTH(256), .ADDR_W(8), .RELEASE_DELAY(4)) dut (
        .clk(clk), .reset(reset), .start(start), .bus(s),
        .cpu_reset(cpu_reset), .load_done(load_done),
        .load_error(load_error), .word_count(word_count)
    );

    imem_stream_loader #(.IMEM_DEPTH(4), .ADDR_W(2), .RELEASE_DELAY(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .bus(s4),
        .cpu_reset(cpu_reset4), .load_done(load_done4),
        .load_error(load_error4), .word_count(word_count4)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    logic [31:0] w4_addr[$];
    int          rel_cyc = -1;
    logic        ld_at_rel = 1'b0;
    logic        cr_prev = 1'b1;

    always @(negedge clk) begin
        if (s.imem_we) begin
            wr_addr.push_back(32'(s.imem_addr));
            wr_data.push_back(s.imem_wdata);
            wr_cyc.push_back(cyc);
        end
        if (cr_prev && !cpu_reset) begin
            rel_cyc   = cyc;
            ld_at_rel = load_done;
        end
        cr_prev = cpu_reset;
        if (s4.imem_we) w4_addr.push_back(32'(s4.imem_addr));
    end

    logic [31:0] prog [5] = '{32'h00500093, 32'h00108113, 32'h001001B3,
                              32'h00108213, 32'h00000000};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input bit w4, input logic [7:0] b, input bit rnd);
        bit done = 1'b0;
        int n = 0;
        while (!done) begin
            @(negedge clk);
            n++;
            if (rnd && $urandom_range(0, 1) == 0) begin
                if (w4) s4.in_valid = 1'b0; else s.in_valid = 1'b0;
            end else if (w4) begin
                s4.in_valid = 1'b1; s4.in_data = b; done = s4.in_ready;
            end else begin
                s.in_valid = 1'b1; s.in_data = b; done = s.in_ready;
            end
            if (!done && n > 100) begin
                checks++; errors++;
                $error("FAIL send_timeout: observed=ready low expected=ready high");
                done = 1'b1;
            end
        end
    endtask

    task automatic send_word(input bit w4, input logic [31:0] w, input bit rnd);
        for (int k = 0; k < 4; k++) send_byte(w4, w[8*k +: 8], rnd);
    endtask

    task automatic idle();
        @(negedge clk);
        s.in_valid = 1'b0;
        s4.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!load_done && n < 50) begin @(negedge clk); n++; end
        chk(tag, load_done, 1'b1);
    endtask

    task automatic clear_log();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        rel_cyc = -1;
    endtask

    task automatic check_prog(input string tag);
        chk({tag, "_nwr"}, wr_addr.size(), 5);
        for (int i = 0; i < 5 && i < wr_addr.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), wr_addr[i], i);
            chk($sformatf("%s_data%0d", tag, i), wr_data[i], prog[i]);
        end
    endtask

    initial begin
        s.in_valid = 1'b0; s.in_data = 8'h00;
        s4.in_valid = 1'b0; s4.in_data = 8'h00;

        // Reset values
        #12;
        chk("rst_cpu_reset", cpu_reset, 1'b1);
        chk("rst_in_ready", s.in_ready, 1'b0);
        chk("rst_we", s.imem_we, 1'b0);
        chk("rst_addr", s.imem_addr, 0);
        chk("rst_wdata", s.imem_wdata, 0);
        chk("rst_done_err", {load_done, load_error}, 2'b00);
        chk("rst_wcount", word_count, 0);
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_in_ready", s.in_ready, 1'b0);
        chk("idle_cpu_reset", cpu_reset, 1'b1);

        // Continuous stream
        pulse_start();
        chk("load_in_ready", s.in_ready, 1'b1);
        for (int i = 0; i < 5; i++) send_word(1'b0, prog[i], 1'b0);
        idle();
        chk("term_in_ready", s.in_ready, 1'b0);
        chk("term_cpu_reset", cpu_reset, 1'b1);
        wait_done("cont_done");
        repeat (3) @(negedge clk);
        check_prog("cont");
        chk("cont_wcount", word_count, 5);
        chk("cont_b2b", wr_cyc[3] - wr_cyc[0], 12);
        chk("cont_rel_delay", rel_cyc - wr_cyc[4], 4);
        chk("cont_done_at_rel", ld_at_rel, 1'b1);
        chk("run_cpu_reset", cpu_reset, 1'b0);
        chk("run_in_ready", s.in_ready, 1'b0);

        // Restart from RUN with gapped valid
        clear_log();
        pulse_start();
        chk("rst_run_cpu_reset", cpu_reset, 1'b1);
        chk("rst_run_load_done", load_done, 1'b0);
        chk("rst_run_wcount", word_count, 0);
        for (int i = 0; i < 5; i++) send_word(1'b0, prog[i], 1'b1);
        idle();
        chk("rnd_term_in_ready", s.in_ready, 1'b0);
        wait_done("rnd_done");
        repeat (3) @(negedge clk);
        check_prog("rnd");
        chk("rnd_rel_delay", rel_cyc - wr_cyc[4], 4);

        // Restart after six bytes discards the partial word
        clear_log();
        pulse_start();
        send_word(1'b0, 32'hAABBCCDD, 1'b0);
        send_byte(1'b0, 8'h55, 1'b0);
        send_byte(1'b0, 8'h66, 1'b0);
        idle();
        @(negedge clk);
        chk("part_nwr", wr_addr.size(), 1);
        chk("part_data", wr_data[0], 32'hAABBCCDD);
        clear_log();
        pulse_start();
        chk("part_wcount_clr", word_count, 0);
        send_word(1'b0, 32'h11223344, 1'b0);
        send_word(1'b0, 32'h00000000, 1'b0);
        idle();
        wait_done("part_done");
        chk("part2_nwr", wr_addr.size(), 2);
        chk("part2_addr0", wr_addr[0], 0);
        chk("part2_data0", wr_data[0], 32'h11223344);
        chk("part2_addr1", wr_addr[1], 1);
        chk("part2_data1", wr_data[1], 32'h00000000);
        chk("part2_wcount", word_count, 2);

        // Asynchronous reset mid-word
        pulse_start();
        send_word(1'b0, 32'hDEADBEEF, 1'b0);
        send_byte(1'b0, 8'h12, 1'b0);
        send_byte(1'b0, 8'h34, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_cpu_reset", cpu_reset, 1'b1);
        chk("arst_in_ready", s.in_ready, 1'b0);
        chk("arst_addr_wdata", {s.imem_addr, s.imem_wdata}, 0);
        chk("arst_misc", {s.imem_we, load_done, load_error, word_count}, 0);
        s.in_valid = 1'b0;
        clear_log();
        repeat (3) @(negedge clk);
        chk("arst_no_wr", wr_addr.size(), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("arst_idle_ready", s.in_ready, 1'b0);
        pulse_start();
        send_word(1'b0, prog[0], 1'b0);
        send_word(1'b0, 32'h00000000, 1'b0);
        idle();
        wait_done("arst_done");
        chk("arst_nwr", wr_addr.size(), 2);
        chk("arst_w0", {wr_addr[0], wr_data[0]}, {32'd0, prog[0]});
        chk("arst_w1", {wr_addr[1], wr_data[1]}, {32'd1, 32'd0});

        // Overflow on the 4-word instance
        @(negedge clk); start4 = 1'b1;
        @(negedge clk); start4 = 1'b0;
        for (int i = 0; i < 4; i++) send_word(1'b1, 32'h01010101 * (i + 1), 1'b0);
        @(negedge clk); s4.in_data = 8'h77;
        repeat (10) @(negedge clk);
        chk("ovf_nwr", w4_addr.size(), 4);
        for (int i = 0; i < 4 && i < w4_addr.size(); i++)
            chk($sformatf("ovf_addr%0d", i), w4_addr[i], i);
        chk("ovf_error", load_error4, 1'b1);
        chk("ovf_cpu_reset", cpu_reset4, 1'b1);
        chk("ovf_in_ready", s4.in_ready, 1'b0);
        chk("ovf_done", load_done4, 1'b0);
        chk("ovf_wcount", word_count4, 4);
        s4.in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
Upstream boot block for cpu_pipelined. It accepts a little-endian byte stream over a valid/ready handshake and packs it into 32-bit instruction words. It writes those words sequentially into the instruction memory write port while holding the CPU in reset, then releases the CPU after a programmable drain delay. This replaces direct memory pokes for program loading; the all-zero word is the program terminator, matching the CPU's end-of-program convention.

Parameters:
IMEM_DEPTH, 256, instruction memory depth in 32-bit words (power of 2, >=4)
ADDR_W, 8, word-address width, equals log2(IMEM_DEPTH)
RELEASE_DELAY, 4, cycles cpu_reset stays high after the terminator write (>=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low
start  in  1  single-cycle pulse; begins (or restarts) a load
in_valid  in  1  byte stream valid
in_ready  out  1  byte stream ready
in_data  in  8  stream byte
imem_we  out  1  instruction memory write enable (one cycle per word)
imem_addr  out  ADDR_W  word address of write
imem_wdata  out  32  write data
cpu_reset  out  1  active-high reset to cpu_pipelined
load_done  out  1  high while CPU is released (RUN)
load_error  out  1  high in ERROR
word_count  out  ADDR_W+1  words written in current/last load, terminator included

Behaviour:
- Reset (async, reset=0): state IDLE; cpu_reset=1; in_ready=0; imem_we=0; imem_addr=0; imem_wdata=0; load_done=0; load_error=0; word_count=0; byte index=0.
- States: IDLE, LOAD, RELEASE, RUN, ERROR. All outputs are registered.
- start in any state -> LOAD on the next cycle. Clears byte index, word address and word_count; forces cpu_reset=1, load_done=0, load_error=0. Any partially packed word is discarded. start beats all other events in the same cycle.
- in_ready=1 only in LOAD and not in the cycle after the terminator byte is accepted. A byte transfers when in_valid&&in_ready.
- Byte k (k=0..3) of a word goes to bits [8k+7:8k]. Gaps in in_valid are allowed; the packing state is held.
- Latency: when the 4th byte is accepted in cycle N, cycle N+1 has imem_we=1, imem_addr=current address, imem_wdata=packed word, and word_count increments. Back-to-back words are sustained at 4 cycles/word with no bubble.
- Terminator (packed word == 32'h0): the word is still written. LOAD -> RELEASE in the write cycle; in_ready=0 from cycle N+1.
- Overflow: a nonzero word written at address IMEM_DEPTH-1 -> ERROR. ERROR holds cpu_reset=1, load_error=1, in_ready=0, and is left only by start or reset.
- A terminator written at IMEM_DEPTH-1 is legal and goes to RELEASE.
- The address never wraps.
- RELEASE: a down-counter loaded with RELEASE_DELAY. cpu_reset is first low, and load_done first high, exactly RELEASE_DELAY cycles after the terminator write cycle. Then state RUN.
- RUN: cpu_reset=0, load_done=1, in_ready=0; holds until start or reset.
- imem_we is never asserted outside the word-write cycles above.
- Reset mid-load returns all outputs to reset values immediately; no further writes occur.

Decomposition:
- Package imem_loader_pkg: state enum, TERMINATOR_WORD=32'h0, BYTES_PER_WORD=4.
- Sub-module byte_word_packer: byte index counter, shift/assemble register, word_valid pulse; cleared by start.
- The top level holds the FSM, address/word counters and release counter.

Test Plan:
- Stream 20 bytes encoding 0x00500093, 0x00108113, 0x001001B3, 0x00108213, 0x00000000 with continuous valid -> writes at addr 0..4 with those data; word_count=5; cpu_reset low exactly 4 cycles after the addr-4 write; load_done=1.
- Same stream with in_valid toggled randomly (50%) -> identical writes/order; no extra imem_we pulses; in_ready=0 after terminator.
- IMEM_DEPTH=4, four nonzero words -> 4 writes, load_error=1, cpu_reset stays 1, in_ready=0; a fifth word is never accepted.
- start pulse after 6 bytes of a load -> next write is at addr 0 with bytes sent after the restart; the stale partial word is never written.
- Async reset asserted mid-word, then released and start -> all outputs at reset values during reset; the reload writes from addr 0 correctly.
- In RUN, pulse start -> cpu_reset=1 and load_done=0 next cycle; a new 2-word program (one word + terminator) loads and releases again.
